multu_ctrl: RTL and testbench

MULTU_CTRL -- requirements
Module: multu_ctrl

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/hilo_regs.sv | 38 +++
 rtl/multu_ctrl.sv | 109 ++++++++++
 tb/tb_multu_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared function codes, FSM encoding and iteration count for the multiply unit
package mdu_pkg;

    // Function codes presented on Signal
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    // One shift-add iteration per multiplier bit
    localparam int unsigned ITERATIONS = 32;
    localparam logic [5:0]  LAST_COUNT = 6'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for the two HI/LO read codes
    function automatic logic is_move_from(input logic [5:0] fn);
        return (fn == FN_MFHI) || (fn == FN_MFLO);
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// rtl/hilo_regs.sv - HI/LO product registers with combinational read mux
module hilo_regs
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic [5:0]  sel,
    output logic [31:0] rd_data
);

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Both halves are written together so a partial product is never observable
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (we) begin
            hi_q <= hi_in;
            lo_q <= lo_in;
        end
    end

    // Read mux: HI for MFHI, LO for MFLO, zero for any other code
    always_comb begin
        rd_data = 32'd0;
        if (sel == FN_MFHI) begin
            rd_data = hi_q;
        end else if (sel == FN_MFLO) begin
            rd_data = lo_q;
        end
    end

endmodule

// File: rtl/multu_ctrl.sv
// rtl/multu_ctrl.sv - iterative 32x32 unsigned shift-add multiplier with HI/LO read-back
module multu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  Signal,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] dataOut
);

    state_t      state;
    state_t      next_state;

    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplr;
    logic [5:0]  count;

    logic        load;
    logic        step;
    logic        wr_hilo;
    logic [63:0] acc_next;

    // Conditional add of the shifted multiplicand; carry out of bit 63 falls off
    assign acc_next = mplr[0] ? (acc + mcand) : acc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode; starts outside IDLE are simply dropped
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        wr_hilo    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && (Signal == FN_MULTU)) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                // No early exit: always the full iteration count
                if (count == LAST_COUNT) begin
                    wr_hilo    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shift-add datapath and iteration counter
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= 64'd0;
            mcand <= 64'd0;
            mplr  <= 32'd0;
            count <= 6'd0;
        end else if (load) begin
            acc   <= 64'd0;
            mcand <= {32'd0, dataA};
            mplr  <= dataB;
            count <= 6'd0;
        end else if (step) begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            count <= count + 6'd1;
        end
    end

    // Reads of HI/LO while iterating must hold the pipeline; they see the old product
    assign stall = busy & is_move_from(Signal);

    hilo_regs u_hilo_regs (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_hilo),
        .hi_in   (acc_next[63:32]),
        .lo_in   (acc_next[31:0]),
        .sel     (Signal),
        .rd_data (dataOut)
    );

endmodule

// File: tb/tb_multu_ctrl.sv
// tb/tb_multu_ctrl.sv - scoreboard bench for multu_ctrl
module tb_multu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] dataOut;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;

    multu_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .Signal  (Signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected {HI,LO} and checks the read port
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got done=1 with empty scoreboard at %0t", $time);
            end else begin
                mon_exp = sb_q.pop_front();
                if (Signal == FN_MFHI) begin
                    if (dataOut !== mon_exp[63:32]) begin
                        bad++;
                        $display("FAIL done_hi: got 0x%0h expected 0x%0h", dataOut, mon_exp[63:32]);
                    end
                end else if (Signal == FN_MFLO) begin
                    if (dataOut !== mon_exp[31:0]) begin
                        bad++;
                        $display("FAIL done_lo: got 0x%0h expected 0x%0h", dataOut, mon_exp[31:0]);
                    end
                end else if (dataOut !== 32'd0) begin
                    bad++;
                    $display("FAIL done_other: got 0x%0h expected 0x0", dataOut);
                end
                chk("done_stall", {63'd0, stall}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig);
        start  = 1'b1;
        Signal = sig;
        dataA  = a;
        dataB  = b;
        tick();
        start  = 1'b0;
    endtask

    // Bounded wait; returns at the negedge of the done cycle
    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 40);
        chk(name, {63'd0, done}, 64'd1);
    endtask

    // Full multiply with latency check; sig_run is held on Signal while iterating
    task automatic run_full(input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] prod, input logic [5:0] sig_run);
        int busy_cycles;
        sb_q.push_back(prod);
        issue(a, b, FN_MULTU);
        Signal = sig_run;
        busy_cycles = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && done === 1'b0) busy_cycles++;
        end
        chk("busy_cycles", busy_cycles, 32);
        @(negedge clk);
        chk("done_cycle33", {63'd0, done}, 64'd1);
        tick();
        chk("idle_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0;
        reset  = 1'b1;
        start  = 1'b0;
        Signal = 6'd0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        Signal = FN_MFHI;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_hi", dataOut, 64'd0);
        Signal = FN_MFLO;
        #1;
        chk("rst_lo", dataOut, 64'd0);
        tick();

        // 3*5
        run_full(32'd3, 32'd5, 64'h0000_0000_0000_000F, FN_MFLO);
        Signal = FN_MFHI;
        #1;
        chk("3x5_hi", dataOut, 64'd0);

        // Max operands
        run_full(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, FN_MFHI);
        Signal = FN_MFLO;
        #1;
        chk("max_lo", dataOut, 64'h1);

        // Non-MULTU start in IDLE is ignored
        d0 = done_cnt;
        issue(32'd7, 32'd7, FN_MFHI);
        @(negedge clk);
        chk("mfhi_idle_busy", {63'd0, busy}, 64'd0);
        chk("mfhi_idle_data", dataOut, 64'hFFFF_FFFE);
        repeat (35) tick();
        chk("mfhi_idle_nodone", done_cnt - d0, 0);

        // 7*6, then abort a second multiply with reset at cycle 10
        run_full(32'd7, 32'd6, 64'd42, FN_MFLO);
        d0 = done_cnt;
        issue(32'd0, 32'h1234_5678, FN_MULTU);
        Signal = FN_MFLO;
        repeat (9) tick();
        chk("abort_old_lo", dataOut, 64'd42);
        chk("abort_stall", {63'd0, stall}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_lo", dataOut, 64'd0);
        Signal = FN_MFHI;
        #1;
        chk("abort_hi", dataOut, 64'd0);
        repeat (40) tick();
        chk("abort_nodone", done_cnt - d0, 0);

        // Reset wins over start in the same cycle
        reset = 1'b1;
        issue(32'd5, 32'd5, FN_MULTU);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("rst_prio_busy2", {63'd0, busy}, 64'd0);

        // 2*4, then MFLO during the 9*9 run stalls and reads old LO
        run_full(32'd2, 32'd4, 64'd8, FN_MFLO);
        sb_q.push_back(64'd81);
        issue(32'd9, 32'd9, FN_MULTU);
        Signal = 6'd0;
        @(negedge clk);
        chk("no_stall_other", {63'd0, stall}, 64'd0);
        repeat (4) tick();
        Signal = FN_MFLO;
        @(negedge clk);
        chk("stall_mflo", {63'd0, stall}, 64'd1);
        chk("stall_old_lo", dataOut, 64'd8);
        wait_done("9x9_done");
        tick();

        // Second start while running is ignored
        d0 = done_cnt;
        sb_q.push_back(64'd100);
        issue(32'd10, 32'd10, FN_MULTU);
        repeat (3) tick();
        issue(32'd2, 32'd2, FN_MULTU);
        Signal = FN_MFLO;
        wait_done("10x10_done");
        repeat (40) tick();
        chk("one_done_pulse", done_cnt - d0, 1);
        chk("10x10_lo", dataOut, 64'd100);

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
